clock_divider_bank: RTL and testbench

Parametrised multi-channel clock divider. It generates NUM_CH independent tick pulses and square-wave enables from the single system clock. Each channel's divisor is reprogrammable at run time and changes glitch-free at the channel's next wrap. A global sync restarts all channels phase-aligned. It replaces the fixed 1 Hz / 10 Hz / 100 Hz / 2 kHz dividers feeding the display scan, debouncers and game timers.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clock_divider_bank_if.sv | 27 ++
 rtl/clock_divider_ch.sv | 73 +++++++
 rtl/clock_divider_bank.sv | 47 ++++
 tb/tb_clock_divider_bank.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and divisor clamp for the clock divider bank.
// Divisors are full periods in 100 MHz system clock cycles.
package clkdiv_pkg;

  localparam int CLK_HZ    = 100_000_000;
  localparam int DIV_1HZ   = 100_000_000;
  localparam int DIV_10HZ  = 10_000_000;
  localparam int DIV_100HZ = 1_000_000;
  localparam int DIV_2KHZ  = 50_000;
  localparam int DIV_MIN   = 2;

  // Works on a 32-bit container; callers cast to and from their own CNT_W.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Control and output bundle for clock_divider_bank.
// cfg_we_i acts as a valid with no ready: a write is always accepted on the edge where it is high.
interface clock_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en_i;
  logic              sync_i;
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [CNT_W-1:0]  cfg_div_i;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] sq_o;
  logic [NUM_CH-1:0] pending_o;

  modport master (
    output en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_div_i,
    input  tick_o, sq_o, pending_o
  );

  modport slave (
    input  en_i, sync_i, cfg_we_i, cfg_ch_i, cfg_div_i,
    output tick_o, sq_o, pending_o
  );
endinterface

// File: rtl/clock_divider_ch.sv
// One divider channel: period counter, active/shadow divisor, tick and square outputs.
// A new divisor is staged in shadow and only promoted at a wrap or a sync.
module clock_divider_ch
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W    = 27,
  parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_MIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             sq,
  output logic             pending
);

  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(clamp_div(32'(DIV_INIT)));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] div_c;
  logic [CNT_W:0]   cnt_inc;
  logic             wrap;

  assign div_c   = CNT_W'(clamp_div(32'(div)));
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign wrap    = (cnt == active - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      active  <= INIT_C;
      shadow  <= INIT_C;
      pending <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      if (we) shadow <= div_c;
      if (sync) begin
        // Same-cycle write bypasses the shadow so the restart uses it at once.
        cnt     <= '0;
        tick    <= 1'b0;
        sq      <= 1'b1;
        pending <= 1'b0;
        if (we)           active <= div_c;
        else if (pending) active <= shadow;
      end else begin
        if (en) begin
          if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            sq   <= 1'b1;
            if (pending) active <= shadow;
          end else begin
            cnt  <= cnt_inc[CNT_W-1:0];
            tick <= 1'b0;
            sq   <= (cnt_inc < {1'b0, active[CNT_W-1:1]});
          end
        end else begin
          tick <= 1'b0;
        end
        // A write on the wrap edge stays pending for the following wrap.
        if (we)               pending <= 1'b1;
        else if (en && wrap)  pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent clock dividers sharing one config write port and a global sync.
// Holds only the write decode and per-channel fan-out.
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(DIV_2KHZ), CNT_W'(DIV_100HZ),
                                                 CNT_W'(DIV_10HZ), CNT_W'(DIV_1HZ)}
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_divider_bank_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] we_c;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] sq_w;
  logic [NUM_CH-1:0] pending_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Channel numbers at or above NUM_CH never match and are dropped.
    assign we_c[c] = bus.cfg_we_i && (bus.cfg_ch_i == CH_W'(c));

    clock_divider_ch #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT[c*CNT_W +: CNT_W])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en_i[c]),
      .sync    (bus.sync_i),
      .we      (we_c[c]),
      .div     (bus.cfg_div_i),
      .tick    (tick_w[c]),
      .sq      (sq_w[c]),
      .pending (pending_w[c])
    );
  end

  assign bus.tick_o    = tick_w;
  assign bus.sq_o      = sq_w;
  assign bus.pending_o = pending_w;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: randomized and directed stimulus against a
// countdown-based reference model, compared through an expected-value queue.
module tb_clock_divider_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int EW     = 3 * NUM_CH;

  logic clk = 1'b0;
  logic rst;

  clock_divider_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus();

  clock_divider_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({16'd3, 16'd2, 16'd5, 16'd4})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // Reference model: each channel counts down the edges left in its period.
  int m_div [NUM_CH];
  int m_sh  [NUM_CH];
  int m_rem [NUM_CH];
  bit m_pend[NUM_CH];
  bit m_sq  [NUM_CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_div[0] = 4; m_div[1] = 5; m_div[2] = 2; m_div[3] = 3;
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh[c]   = m_div[c];
      m_rem[c]  = m_div[c];
      m_pend[c] = 1'b0;
      m_sq[c]   = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [NUM_CH-1:0] en, input logic sy, input logic we,
                            input logic [1:0] ch, input int d);
    logic [EW-1:0] e;
    int nd;
    bit wr;
    bit tk;
    nd = (d < 2) ? 2 : d;
    e  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr = we && (int'(ch) == c);
      tk = 1'b0;
      if (sy) begin
        if (wr)          m_div[c] = nd;
        else if (m_pend[c]) m_div[c] = m_sh[c];
        if (wr) m_sh[c] = nd;
        m_pend[c] = 1'b0;
        m_rem[c]  = m_div[c];
        m_sq[c]   = 1'b1;
      end else begin
        if (en[c]) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            tk = 1'b1;
            if (m_pend[c]) begin
              m_div[c]  = m_sh[c];
              m_pend[c] = 1'b0;
            end
            m_rem[c] = m_div[c];
            m_sq[c]  = 1'b1;
          end else begin
            m_sq[c] = ((m_div[c] - m_rem[c]) < (m_div[c] / 2));
          end
        end
        if (wr) begin
          m_sh[c]   = nd;
          m_pend[c] = 1'b1;
        end
      end
      e[c]            = tk;
      e[NUM_CH + c]   = m_sq[c];
      e[2*NUM_CH + c] = m_pend[c];
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [NUM_CH-1:0] en, input logic sy, input logic we,
                      input logic [1:0] ch, input int d);
    bus.en_i      = en;
    bus.sync_i    = sy;
    bus.cfg_we_i  = we;
    bus.cfg_ch_i  = ch;
    bus.cfg_div_i = CNT_W'(d);
    @(posedge clk);
    model_edge(en, sy, we, ch, d);
    #1;
    bus.sync_i   = 1'b0;
    bus.cfg_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'hF, 1'b0, 1'b0, 2'd0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("outputs{pend,sq,tick}", 32'({bus.pending_o, bus.sq_o, bus.tick_o}), 32'(mon_e));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_CH-1:0] r_en;
    rst           = 1'b1;
    bus.en_i      = 4'hF;
    bus.sync_i    = 1'b0;
    bus.cfg_we_i  = 1'b0;
    bus.cfg_ch_i  = '0;
    bus.cfg_div_i = '0;
    model_reset();

    #12;
    check("reset_tick", 32'(bus.tick_o), 32'h0);
    check("reset_sq", 32'(bus.sq_o), 32'h0);
    check("reset_pending", 32'(bus.pending_o), 32'h0);
    rst = 1'b0;

    // Reset divisors: ch0=4, ch1=5, ch2=2, ch3=3.
    idle(20);

    // Write D=3 to ch0 on the edge where it wraps.
    for (int i = 0; i < 10 && m_rem[0] != 1; i++) idle(1);
    check("wrap_align", 32'(m_rem[0]), 32'd1);
    step(4'hF, 1'b0, 1'b1, 2'd0, 3);
    idle(12);

    // Runtime change of ch0 to 6 mid-period.
    idle(1);
    step(4'hF, 1'b0, 1'b1, 2'd0, 6);
    idle(20);

    // Clamp: 0 and 1 both become 2 on ch1.
    step(4'hF, 1'b0, 1'b1, 2'd1, 0);
    step(4'hF, 1'b0, 1'b1, 2'd1, 1);
    idle(16);

    // Back-to-back writes before a wrap; the last one wins.
    step(4'hF, 1'b0, 1'b1, 2'd2, 9);
    step(4'hF, 1'b0, 1'b1, 2'd2, 4);
    idle(12);

    // Sync with a simultaneous write of 7 to ch3, plus a pending write on ch1.
    step(4'hF, 1'b0, 1'b1, 2'd1, 3);
    step(4'hF, 1'b1, 1'b1, 2'd3, 7);
    idle(16);

    // Drop en_i[0] for three cycles mid-period.
    idle(2);
    repeat (3) step(4'hE, 1'b0, 1'b0, 2'd0, 0);
    idle(14);

    // Randomized traffic.
    repeat (400) begin
      for (int b = 0; b < NUM_CH; b++) r_en[b] = ($urandom_range(0, 9) != 0);
      step(r_en, ($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0),
           2'($urandom_range(0, NUM_CH-1)), int'($urandom_range(0, 9)));
    end
    idle(4);

    // Asynchronous reset mid-period, checked before any clock edge.
    step(4'hF, 1'b0, 1'b1, 2'd0, 8);
    idle(1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_tick", 32'(bus.tick_o), 32'h0);
    check("async_rst_sq", 32'(bus.sq_o), 32'h0);
    check("async_rst_pending", 32'(bus.pending_o), 32'h0);
    exp_q.delete();
    model_reset();
    #1;
    rst = 1'b0;
    idle(24);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
